// File: rtl/frame_loader.sv
// Packs a stream of audio samples into BUS_W-bit words, loads one frame into the AudioProcessor, then starts it and waits for done.
// Optional build macro FRAME_LOADER_BYTE_SWAP_EN byte-swaps each sample before packing.
module frame_loader #(
    parameter int SAMPLE_W    = 16,
    parameter int BUS_W       = 512,
    parameter int FRAME_WORDS = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    input  logic [SAMPLE_W-1:0] s_sample,
    output logic                s_ready,
    output logic                ap_data_wr_en,
    output logic [5:0]          ap_input_index,
    output logic [BUS_W-1:0]    ap_data_in,
    output logic                ap_start,
    input  logic                ap_done,
    output logic                busy,
    output logic [15:0]         frame_cnt
);

    localparam int SPW                    = BUS_W / SAMPLE_W;
    localparam int SIDX_W                 = (SPW > 1) ? $clog2(SPW) : 1;
    localparam logic [SIDX_W-1:0] LAST_SAMPLE = SIDX_W'(SPW - 1);
    localparam logic [5:0] LAST_WORD      = 6'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {FILL, START, WAIT} loaderState;

    loaderState          r_state;
    logic [SIDX_W-1:0]   r_sampleIdx;
    logic [5:0]          r_wordIdx;
    logic [BUS_W-1:0]    r_pack;
    logic [BUS_W-1:0]    r_dataOut;
    logic [5:0]          r_index;
    logic                r_wrEn;
    logic                r_start;
    logic                r_doneLast;
    logic [15:0]         r_frameCnt;

    logic [SAMPLE_W-1:0] w_sample;
    logic [BUS_W-1:0]    w_word;
    logic                w_accept;
    logic                w_doneRise;

`ifdef FRAME_LOADER_BYTE_SWAP_EN
    always_comb begin
        w_sample = '0;
        for (int b = 0; b < SAMPLE_W / 8; b++) begin
            w_sample[b*8 +: 8] = s_sample[SAMPLE_W-8-b*8 +: 8];
        end
    end
`else
    always_comb begin
        w_sample = s_sample;
    end
`endif

    // The word as it will look once the incoming sample lands in its slot.
    always_comb begin
        w_word = r_pack;
        w_word[int'(r_sampleIdx)*SAMPLE_W +: SAMPLE_W] = w_sample;
    end

    assign w_accept   = s_valid && (r_state == FILL);
    assign w_doneRise = ap_done && !r_doneLast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= FILL;
            r_sampleIdx <= '0;
            r_wordIdx   <= '0;
            r_pack      <= '0;
            r_dataOut   <= '0;
            r_index     <= '0;
            r_wrEn      <= 1'b0;
            r_start     <= 1'b0;
            r_doneLast  <= 1'b0;
            r_frameCnt  <= '0;
        end else begin
            r_wrEn     <= 1'b0;
            r_start    <= 1'b0;
            r_doneLast <= ap_done;
            unique case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_pack <= w_word;
                        if (r_sampleIdx == LAST_SAMPLE) begin
                            r_dataOut   <= w_word;
                            r_wrEn      <= 1'b1;
                            r_index     <= r_wordIdx;
                            r_sampleIdx <= '0;
                            if (r_wordIdx == LAST_WORD) begin
                                r_wordIdx <= '0;
                                r_state   <= START;
                            end else begin
                                r_wordIdx <= r_wordIdx + 6'd1;
                            end
                        end else begin
                            r_sampleIdx <= r_sampleIdx + SIDX_W'(1);
                        end
                    end
                end
                START: begin
                    r_start <= 1'b1;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // Only a low->high edge seen while waiting completes the frame.
                    if (w_doneRise) begin
                        r_state     <= FILL;
                        r_frameCnt  <= r_frameCnt + 16'd1;
                        r_sampleIdx <= '0;
                        r_wordIdx   <= '0;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign s_ready        = (r_state == FILL);
    assign busy           = (r_state != FILL);
    assign ap_data_wr_en  = r_wrEn;
    assign ap_input_index = r_index;
    assign ap_data_in     = r_dataOut;
    assign ap_start       = r_start;
    assign frame_cnt      = r_frameCnt;

endmodule

// File: tb/tb_frame_loader.sv
// Self-checking bench for frame_loader: table-driven full frames, hand sequences, and a random run against a sample-queue model.
module tb_frame_loader;

    localparam int SPW = 32;
    localparam int FW  = 64;
    localparam int PH_FILL  = 0;
    localparam int PH_START = 1;
    localparam int PH_WAIT  = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic [15:0]  s_sample = '0;
    logic         s_ready;
    logic         ap_data_wr_en;
    logic [5:0]   ap_input_index;
    logic [511:0] ap_data_in;
    logic         ap_start;
    logic         ap_done = 1'b0;
    logic         busy;
    logic [15:0]  frame_cnt;

    frame_loader dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_sample(s_sample), .s_ready(s_ready),
        .ap_data_wr_en(ap_data_wr_en), .ap_input_index(ap_input_index), .ap_data_in(ap_data_in),
        .ap_start(ap_start), .ap_done(ap_done), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the frame is just the ordered list of accepted samples.
    int           mPhase = PH_FILL;
    logic [15:0]  mFrame[$];
    logic         mWr = 1'b0;
    logic         mStart = 1'b0;
    logic         mAccepted = 1'b0;
    logic         mPrevDone = 1'b0;
    logic [5:0]   mIdx = '0;
    logic [511:0] mData = '0;
    logic [15:0]  mFrameCnt = '0;

    int           dutWrites = 0;
    int           dutStarts = 0;
    logic [511:0] dutWord0 = '0;

    typedef struct {
        int          preSamples;
        bit          doReset;
        logic [15:0] base;
        int          stride;
        int          gap;
        logic [15:0] expLo;
        logic [15:0] expHi;
        logic [15:0] expFrames;
    } frameVec;

    frameVec vecs[4];

    function automatic logic [15:0] swapIf(input logic [15:0] x);
`ifdef FRAME_LOADER_BYTE_SWAP_EN
        return {x[7:0], x[15:8]};
`else
        return x;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPhase = PH_FILL;
        mFrame.delete();
        mWr = 1'b0;
        mStart = 1'b0;
        mAccepted = 1'b0;
        mPrevDone = 1'b0;
        mIdx = '0;
        mData = '0;
        mFrameCnt = '0;
    endtask

    task automatic modelStep(input logic v, input logic [15:0] smp, input logic d);
        int n;
        mWr = 1'b0;
        mStart = 1'b0;
        mAccepted = 1'b0;
        case (mPhase)
            PH_FILL: begin
                if (v) begin
                    mAccepted = 1'b1;
                    mFrame.push_back(swapIf(smp));
                    n = mFrame.size();
                    if (n % SPW == 0) begin
                        mWr = 1'b1;
                        mIdx = 6'(n / SPW - 1);
                        for (int k = 0; k < SPW; k++) mData[k*16 +: 16] = mFrame[n-SPW+k];
                        if (n == SPW * FW) mPhase = PH_START;
                    end
                end
            end
            PH_START: begin
                mStart = 1'b1;
                mPhase = PH_WAIT;
            end
            default: begin
                if (d && !mPrevDone) begin
                    mPhase = PH_FILL;
                    mFrameCnt = mFrameCnt + 16'd1;
                    mFrame.delete();
                end
            end
        endcase
        mPrevDone = d;
    endtask

    task automatic checkAll();
        checkOutput("s_ready", 512'(s_ready), 512'(mPhase == PH_FILL));
        checkOutput("busy", 512'(busy), 512'(mPhase != PH_FILL));
        checkOutput("wr_en", 512'(ap_data_wr_en), 512'(mWr));
        checkOutput("start", 512'(ap_start), 512'(mStart));
        checkOutput("data_in", ap_data_in, mData);
        checkOutput("frame_cnt", 512'(frame_cnt), 512'(mFrameCnt));
        if (mWr) checkOutput("index", 512'(ap_input_index), 512'(mIdx));
        if (ap_data_wr_en) begin
            dutWrites++;
            if (ap_input_index == 6'd0) dutWord0 = ap_data_in;
        end
        if (ap_start) dutStarts++;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] smp, input logic d);
        s_valid = v;
        s_sample = smp;
        ap_done = d;
        @(posedge clk);
        modelStep(v, smp, d);
        #1;
        checkAll();
    endtask

    task automatic doReset();
        rst = 1'b1;
        s_valid = 1'b0;
        ap_done = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_wr_en", 512'(ap_data_wr_en), 512'(0));
        checkOutput("rst_index", 512'(ap_input_index), 512'(0));
        checkOutput("rst_data", ap_data_in, 512'(0));
        checkOutput("rst_start", 512'(ap_start), 512'(0));
        checkOutput("rst_busy", 512'(busy), 512'(0));
        checkOutput("rst_frame_cnt", 512'(frame_cnt), 512'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rst_ready", 512'(s_ready), 512'(1));
    endtask

    task automatic streamSamples(input int n, input logic [15:0] base, input int stride,
                                 input int gap, input logic d);
        int got = 0;
        int cyc = 0;
        int bound = n * (gap + 1) + 64;
        while (got < n && cyc < bound) begin
            if (cyc % (gap + 1) == 0)
                applyStimulus(1'b1, base + 16'(got * stride), d);
            else
                applyStimulus(1'b0, 16'($urandom), d);
            if (mAccepted) got++;
            cyc++;
        end
        checkOutput("stream_count", 512'(got), 512'(n));
    endtask

    task automatic randomRun(input int cycles);
        for (int i = 0; i < cycles; i++)
            applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 7) == 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{preSamples: 0,    doReset: 1'b1, base: 16'h0000, stride: 1, gap: 0,
                    expLo: 16'h0000, expHi: 16'h001F, expFrames: 16'd1};
        vecs[1] = '{preSamples: 1000, doReset: 1'b1, base: 16'h1000, stride: 1, gap: 0,
                    expLo: 16'h1000, expHi: 16'h101F, expFrames: 16'd1};
        vecs[2] = '{preSamples: 0,    doReset: 1'b0, base: 16'hFFF0, stride: 1, gap: 1,
                    expLo: 16'hFFF0, expHi: 16'h000F, expFrames: 16'd2};
        vecs[3] = '{preSamples: 0,    doReset: 1'b0, base: 16'h8000, stride: 3, gap: 2,
                    expLo: 16'h8000, expHi: 16'h805D, expFrames: 16'd3};

        $display("[TB] starting frame_loader bench");
        doReset();

        for (int v = 0; v < 4; v++) begin
            if (vecs[v].preSamples > 0) begin
                dutStarts = 0;
                streamSamples(vecs[v].preSamples, 16'h5A00, 1, 0, 1'b0);
                checkOutput("partial_no_start", 512'(dutStarts), 512'(0));
            end
            if (vecs[v].doReset) doReset();
            dutWrites = 0;
            dutStarts = 0;
            dutWord0 = '0;
            streamSamples(SPW * FW, vecs[v].base, vecs[v].stride, vecs[v].gap, 1'b0);
            // Upstream keeps offering samples while the processor runs.
            for (int i = 0; i < 6; i++) applyStimulus(1'b1, 16'hDEAD, 1'b0);
            checkOutput("wait_ready", 512'(s_ready), 512'(0));
            checkOutput("writes", 512'(dutWrites), 512'(FW));
            checkOutput("starts", 512'(dutStarts), 512'(1));
            checkOutput("word0_lo", 512'(dutWord0[15:0]), 512'(swapIf(vecs[v].expLo)));
            checkOutput("word0_hi", 512'(dutWord0[511:496]), 512'(swapIf(vecs[v].expHi)));
            applyStimulus(1'b0, 16'h0000, 1'b1);
            checkOutput("done_to_fill", 512'(s_ready), 512'(1));
            checkOutput("frames", 512'(frame_cnt), 512'(vecs[v].expFrames));
            applyStimulus(1'b0, 16'h0000, 1'b0);
        end

        // ap_done held high from FILL through START into WAIT must not complete the frame.
        streamSamples(SPW * FW, 16'h0100, 5, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b1);
            checkOutput("held_busy", 512'(busy), 512'(1));
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b0);
            checkOutput("dropped_busy", 512'(busy), 512'(1));
        end
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("held_release", 512'(busy), 512'(0));
        checkOutput("held_frames", 512'(frame_cnt), 512'(4));
        applyStimulus(1'b0, 16'h0000, 1'b0);

        randomRun(6000);

        doReset();
        streamSamples(10, 16'h0042, 1, 0, 1'b0);
        randomRun(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_loader.md
FRAME_LOADER -- requirements
Module: frame_loader

Interface
- REQ-001 SHALL have parameter SAMPLE_W, default 16, bits per audio sample.
- REQ-002 SHALL have parameter BUS_W, default 512, width of the AudioProcessor data bus (BUS_W/SAMPLE_W = 32 samples per word).
- REQ-003 SHALL have parameter FRAME_WORDS, default 64, words per processing frame (2048 samples).
- REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
- REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
- REQ-006 SHALL have port s_valid, input, 1, upstream sample valid.
- REQ-007 SHALL have port s_sample, input, SAMPLE_W, upstream sample, two's complement.
- REQ-008 SHALL have port s_ready, output, 1, loader accepts a sample this cycle.
- REQ-009 SHALL have port ap_data_wr_en, output, 1, AudioProcessor data_wr_en.
- REQ-010 SHALL have port ap_input_index, output, 6, AudioProcessor input_index.
- REQ-011 SHALL have port ap_data_in, output, BUS_W, AudioProcessor data_in.
- REQ-012 SHALL have port ap_start, output, 1, AudioProcessor start.
- REQ-013 SHALL have port ap_done, input, 1, AudioProcessor done.
- REQ-014 SHALL have port busy, output, 1, high in START and WAIT.
- REQ-015 SHALL have port frame_cnt, output, 16, completed frames, wraps 0xFFFF->0x0000.

Function
- REQ-016 A sample SHALL be accepted on a clock edge where s_valid and s_ready are both high.
- REQ-017 Sample k (0..31) within a word SHALL occupy ap_data_in bits [16k+15:16k].
- REQ-018 FSM states SHALL be FILL, START, WAIT; reset state FILL.
- REQ-019 In FILL, s_ready SHALL be high; in START and WAIT low.
- REQ-020 On acceptance of the 32nd sample of a word, the next cycle SHALL present the packed word on ap_data_in with ap_data_wr_en=1 and ap_input_index=word count (0..63), for exactly one cycle.
- REQ-021 Acceptance SHALL continue without bubbles during a write cycle; the pack register restarts at sample 0 the same edge the word is registered.
- REQ-022 ap_data_in SHALL hold its last written value when ap_data_wr_en is low.
- REQ-023 Acceptance of the 2048th sample SHALL move FILL->START; the word-63 write occurs in the START cycle.
- REQ-024 In START, ap_start SHALL be high for exactly one cycle, then WAIT.
- REQ-025 In WAIT, a rising edge of ap_done (low previous cycle, high now) SHALL move WAIT->FILL, increment frame_cnt, and reset word/sample counters to 0.
- REQ-026 ap_done high during START or already high on entry to WAIT SHALL NOT count; only a fresh low->high edge observed in WAIT completes the frame.
- REQ-027 ap_done edges in FILL SHALL be ignored.
- REQ-028 s_valid low SHALL stall packing indefinitely with no state change.

Reset
- REQ-029 rst SHALL immediately clear: state=FILL, s_ready=1 after release, ap_data_wr_en=0, ap_input_index=0, ap_data_in=0, ap_start=0, busy=0, frame_cnt=0, pack/word counters=0.
- REQ-030 rst asserted mid-frame SHALL discard the partial frame; no ap_start issued for it.

Configuration
- REQ-031 Macro FRAME_LOADER_BYTE_SWAP_EN defined: each sample SHALL be byte-swapped (s_sample[7:0] to bits [15:8]) before packing.
- REQ-032 Macro undefined: samples SHALL be packed unmodified.

Verification
- REQ-033 Reset, stream samples 0..2047 continuously -> 64 write pulses, indices 0..63, word 0 bits[15:0]=0x0000 and bits[511:496]=0x001F, ap_start one cycle after the last write.
- REQ-034 Hold s_valid high in WAIT -> s_ready=0, no samples accepted; pulse ap_done -> FILL next cycle, frame_cnt=1.
- REQ-035 Toggle s_valid every other cycle through one word -> single write pulse with samples in order, index 0.
- REQ-036 Assert rst after 1000 samples, then stream 2048 samples 0x1000+n -> indices restart at 0, word 0 bits[15:0]=0x1000, one ap_start.
- REQ-037 Hold ap_done high throughout START and into WAIT -> remain in WAIT until ap_done drops and rises again.
- REQ-038 With FRAME_LOADER_BYTE_SWAP_EN, sample 0x1234 at index 0 -> ap_data_in[15:0]=0x3412.
